// File: rtl/gray_ptr_sync_rx.sv
// Receive-side pointer stage of a dual-clock FIFO: resynchronises a remote Gray
// pointer, decodes it, derives level/empty/full and flags Gray-coding or range errors.
module gray_ptr_sync_rx #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit READ_SIDE   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] remote_gray_i,
  input  logic [W-1:0] local_bin_i,
  output logic [W-1:0] remote_bin_o,
  output logic [W-1:0] level_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         step_o,
  output logic         err_o,
  input  logic         err_clr_i
);

  localparam logic [W-1:0] DEPTH     = {1'b1, {(W-1){1'b0}}};
  localparam int           WARM      = SYNC_STAGES + 1;
  localparam int           CW        = $clog2(WARM + 1);
  localparam logic [CW-1:0] WARM_DONE = CW'(WARM);

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int j = W - 2; j >= 0; j--) begin
      b[j] = g[j] ^ b[j+1];
    end
    return b;
  endfunction

  // d & (d - 1) clears the lowest set bit, so a nonzero result means two or more bits set
  function automatic logic multi_bit(input logic [W-1:0] d);
    return (d & (d - {{(W-1){1'b0}}, 1'b1})) != {W{1'b0}};
  endfunction

  logic [W-1:0]  sync_r [SYNC_STAGES];
  logic [W-1:0]  g_sync_s;
  logic [W-1:0]  g_prev_r;
  logic [W-1:0]  remote_bin_r;
  logic          step_r;
  logic          err_r;
  logic [CW-1:0] warm_cnt_r;
  logic [W-1:0]  level_s;
  logic          coding_err_s;
  logic          range_err_s;
  logic          err_set_s;

  // Resync chain: plain flop-to-flop, only the last stage fans out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {W{1'b0}};
      end
    end else begin
      sync_r[0] <= remote_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign g_sync_s = sync_r[SYNC_STAGES-1];

  // Previous sample, decoded pointer and change pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_prev_r     <= {W{1'b0}};
      remote_bin_r <= {W{1'b0}};
      step_r       <= 1'b0;
    end else begin
      g_prev_r     <= g_sync_s;
      remote_bin_r <= gray2bin(g_sync_s);
      step_r       <= (g_sync_s != g_prev_r);
    end
  end

  // Counts the post-reset refill cycles; the coding check stays off until the chain holds real samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm_cnt_r <= {CW{1'b0}};
    end else if (warm_cnt_r != WARM_DONE) begin
      warm_cnt_r <= warm_cnt_r + CW'(1'b1);
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end

  // Level is write pointer minus read pointer, wrapping modulo 2**W
  always_comb begin
    level_s = {W{1'b0}};
    if (READ_SIDE) begin
      level_s = remote_bin_r - local_bin_i;
    end else begin
      level_s = local_bin_i - remote_bin_r;
    end
  end

  // Error set sources
  always_comb begin
    coding_err_s = 1'b0;
    if (warm_cnt_r == WARM_DONE) begin
      coding_err_s = multi_bit(g_sync_s ^ g_prev_r);
    end else begin
      coding_err_s = 1'b0;
    end
    range_err_s = (level_s > DEPTH);
    err_set_s   = coding_err_s | range_err_s;
  end

  // Sticky error: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign remote_bin_o = remote_bin_r;
  assign level_o      = level_s;
  assign empty_o      = (level_s == {W{1'b0}});
  assign full_o       = (level_s == DEPTH);
  assign step_o       = step_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_gray_ptr_sync_rx.sv
// Directed plus random bench for gray_ptr_sync_rx; a delay-line model of the
// synchroniser predicts every output of a read-side and a write-side instance.
module tb_gray_ptr_sync_rx;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic [3:0] loc1, loc0;
  logic       clr;

  logic [3:0] bin1, lvl1, bin0, lvl0;
  logic       empty1, full1, step1, err1;
  logic       empty0, full0, step0, err0;

  int errors = 0;
  int checks = 0;

  // model state
  logic [3:0] h [0:7];
  int         n_since = 0;
  logic [3:0] exp_bin = 4'd0;
  logic       exp_step = 1'b0;
  logic       exp_err1 = 1'b0;
  logic       exp_err0 = 1'b0;

  always #5 clk = ~clk;

  gray_ptr_sync_rx #(.W(4), .SYNC_STAGES(S), .READ_SIDE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .remote_gray_i(gray_in), .local_bin_i(loc1),
    .remote_bin_o(bin1), .level_o(lvl1), .empty_o(empty1), .full_o(full1),
    .step_o(step1), .err_o(err1), .err_clr_i(clr)
  );

  gray_ptr_sync_rx #(.W(4), .SYNC_STAGES(S), .READ_SIDE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .remote_gray_i(gray_in), .local_bin_i(loc0),
    .remote_bin_o(bin0), .level_o(lvl0), .empty_o(empty0), .full_o(full0),
    .step_o(step0), .err_o(err0), .err_clr_i(clr)
  );

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    for (int k = 1; k < 4; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    logic [3:0] pre1, pre0, e1, e0;
    logic       cod;
    pre1 = exp_bin - loc1;
    pre0 = loc0 - exp_bin;
    cod  = (n_since >= S + 1) && ($countones(h[S-1] ^ h[S]) > 1);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) h[i] = 4'd0;
      n_since  = 0;
      exp_bin  = 4'd0;
      exp_step = 1'b0;
      exp_err1 = 1'b0;
      exp_err0 = 1'b0;
    end else begin
      exp_step = (h[S-1] != h[S]);
      exp_bin  = g2b(h[S-1]);
      if (cod || pre1 > 4'd8) exp_err1 = 1'b1;
      else if (clr)           exp_err1 = 1'b0;
      if (cod || pre0 > 4'd8) exp_err0 = 1'b1;
      else if (clr)           exp_err0 = 1'b0;
      for (int i = 7; i > 0; i--) h[i] = h[i-1];
      h[0] = gray_in;
      n_since++;
    end
    #1;
    e1 = exp_bin - loc1;
    e0 = loc0 - exp_bin;
    chk("bin1",   bin1,   exp_bin);
    chk("lvl1",   lvl1,   e1);
    chk("empty1", {3'd0, empty1}, {3'd0, e1 == 4'd0});
    chk("full1",  {3'd0, full1},  {3'd0, e1 == 4'd8});
    chk("step1",  {3'd0, step1},  {3'd0, exp_step});
    chk("err1",   {3'd0, err1},   {3'd0, exp_err1});
    chk("bin0",   bin0,   exp_bin);
    chk("lvl0",   lvl0,   e0);
    chk("empty0", {3'd0, empty0}, {3'd0, e0 == 4'd0});
    chk("full0",  {3'd0, full0},  {3'd0, e0 == 4'd8});
    chk("step0",  {3'd0, step0},  {3'd0, exp_step});
    chk("err0",   {3'd0, err0},   {3'd0, exp_err0});
  endtask

  initial begin
    logic [3:0] rb;
    int         r;
    for (int i = 0; i < 8; i++) h[i] = 4'd0;

    // reset with a nonzero pointer on the input
    rst_n = 1'b0; gray_in = 4'b1100; loc1 = 4'd0; loc0 = 4'd0; clr = 1'b0;
    #2;
    tick(); tick(); tick();
    chk("rst_bin",   bin1, 4'd0);
    chk("rst_empty", {3'd0, empty1}, 4'd1);
    chk("rst_err",   {3'd0, err1},   4'd0);

    // latency: gray 0001 reaches remote_bin_o on the third edge
    gray_in = 4'b0001; rst_n = 1'b1;
    tick(); tick();
    chk("lat_early", bin1, 4'd0);
    tick();
    chk("lat_bin",  bin1, 4'd1);
    chk("lat_step", {3'd0, step1}, 4'd1);
    tick();
    chk("lat_step_low", {3'd0, step1}, 4'd0);

    // walk the remote pointer up to 13 with the local pointer trailing
    for (int b = 2; b <= 13; b++) begin
      loc1 = 4'(b - 1);
      gray_in = b2g(4'(b));
      repeat (4) tick();
    end
    loc1 = 4'd13; gray_in = 4'b1001;
    repeat (4) tick();
    loc1 = 4'd14;
    #1;
    chk("wrap_l0", lvl1, 4'd0);
    gray_in = 4'b1000;
    repeat (4) tick();
    chk("wrap_l1", lvl1, 4'd1);
    gray_in = 4'b0000;
    repeat (4) tick();
    chk("wrap_l2", lvl1, 4'd2);
    loc1 = 4'd8;
    #1;
    chk("full", {3'd0, full1}, 4'd1);
    tick();
    chk("full_noerr", {3'd0, err1}, 4'd0);

    // coding error: two bits change at once
    loc1 = 4'd0;
    tick();
    gray_in = 4'b0011;
    tick(); tick();
    chk("cod_pre", {3'd0, err1}, 4'd0);
    tick();
    chk("cod_set", {3'd0, err1}, 4'd1);
    repeat (3) tick();
    chk("cod_sticky", {3'd0, err1}, 4'd1);

    // clear colliding with a new jump loses; a lone clear works
    gray_in = 4'b0000;
    tick(); tick();
    clr = 1'b1;
    tick();
    chk("clr_vs_set", {3'd0, err1}, 4'd1);
    clr = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    chk("clr_ok", {3'd0, err1}, 4'd0);
    clr = 1'b0;

    // range error on the write side, then a mid-stream reset
    loc0 = 4'd0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("range_pre", {3'd0, err0}, 4'd0);
    loc0 = 4'd9;
    #1;
    chk("range_lvl", lvl0, 4'd9);
    tick();
    chk("range_err", {3'd0, err0}, 4'd1);
    loc0 = 4'd6; gray_in = 4'b0110; rst_n = 1'b0;
    tick();
    chk("mid_rst_err", {3'd0, err0}, 4'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_rst_bin", bin0, 4'd4);
    chk("mid_rst_e0",  {3'd0, err0}, 4'd0);
    chk("mid_rst_e1",  {3'd0, err1}, 4'd0);
    repeat (2) tick();

    // random walk with occasional coding faults and clears
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 29);
      if (r == 0) begin
        gray_in = gray_in ^ 4'b0101;
      end else if (r < 12) begin
        rb = g2b(gray_in) + 4'd1;
        gray_in = b2g(rb);
      end
      loc1 = exp_bin - 4'($urandom_range(0, 7));
      loc0 = exp_bin + 4'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
